// File: rtl/integ_term.sv
// Integral term of the servo PID loop: saturating accumulation of Ki*e[k] per sample strobe.
// Define ANTIWINDUP_EN to clamp the accumulator to [-LIM, +LIM] instead of the full N-bit range.
module integ_term #(
    parameter int                     N    = 19,
    parameter int                     FRAC = 10,
    parameter logic signed [N-1:0]    KI   = 19'sd20,
    parameter logic signed [N-1:0]    LIM  = 19'sd200000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_reg,
    input  logic                      clr,
    input  logic signed [N-1:0]       ek_act,
    output logic signed [N-1:0]       out_ik_reg,
    output logic                      busy,
    output logic                      done
);

`ifdef ANTIWINDUP_EN
    localparam bit AW_EN = 1'b1;
`else
    localparam bit AW_EN = 1'b0;
`endif

    localparam logic signed [2*N-1:0] PMAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] PMIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [N:0]     SMAX = {2'b00, {(N-1){1'b1}}};
    localparam logic signed [N:0]     SMIN = {2'b11, {(N-1){1'b0}}};
    localparam logic signed [N:0]     LIMX = {LIM[N-1], LIM};
    localparam logic signed [N:0]     AHI  = AW_EN ? LIMX : SMAX;
    localparam logic signed [N:0]     ALO  = AW_EN ? -LIMX : SMIN;

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    state_t                 state;
    logic signed [N-1:0]    e_reg;
    logic signed [N-1:0]    prod_reg;
    logic signed [N-1:0]    acc;

    // Full-width product, arithmetic shift floors toward -inf before saturating to N bits.
    function automatic logic signed [N-1:0] mul_sat(input logic signed [N-1:0] e);
        logic signed [2*N-1:0] ew;
        logic signed [2*N-1:0] kw;
        logic signed [2*N-1:0] p;
        ew = {{N{e[N-1]}}, e};
        kw = {{N{KI[N-1]}}, KI};
        p  = (ew * kw) >>> FRAC;
        if (p > PMAX)
            mul_sat = PMAX[N-1:0];
        else if (p < PMIN)
            mul_sat = PMIN[N-1:0];
        else
            mul_sat = p[N-1:0];
    endfunction

    function automatic logic signed [N-1:0] acc_sat(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s > AHI)
            acc_sat = AHI[N-1:0];
        else if (s < ALO)
            acc_sat = ALO[N-1:0];
        else
            acc_sat = s[N-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            e_reg      <= '0;
            prod_reg   <= '0;
            acc        <= '0;
            out_ik_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (clr) begin
            // Clear wins over a same-cycle strobe and drops any sample in flight.
            state      <= IDLE;
            acc        <= '0;
            out_ik_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_reg) begin
                        e_reg <= ek_act;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    prod_reg <= mul_sat(e_reg);
                    state    <= ACC;
                end
                ACC: begin
                    acc   <= acc_sat(acc, prod_reg);
                    state <= OUT;
                end
                OUT: begin
                    out_ik_reg <= acc;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integ_term.sv
// Randomised self-checking bench for integ_term against an arithmetic model of the integral term.
module tb_integ_term;

    localparam int N = 19;

    logic                clk;
    logic                rst;
    logic                en_reg;
    logic                clr;
    logic signed [N-1:0] ek_act;
    logic signed [N-1:0] out_ik_reg;
    logic                busy;
    logic                done;

    int     n_checks;
    int     n_fail;
    int     done_cnt;
    longint mdl_acc;

    integ_term dut (
        .clk        (clk),
        .rst        (rst),
        .en_reg     (en_reg),
        .clr        (clr),
        .ek_act     (ek_act),
        .out_ik_reg (out_ik_reg),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

`ifdef ANTIWINDUP_EN
    localparam longint HI = 200000;
    localparam longint LO = -200000;
`else
    localparam longint HI = 262143;
    localparam longint LO = -262144;
`endif

    function automatic longint mdl_prod(longint e);
        longint p;
        p = (e * 20) >>> 10;
        if (p > 262143) p = 262143;
        if (p < -262144) p = -262144;
        return p;
    endfunction

    function automatic void mdl_step(longint e);
        longint s;
        s = mdl_acc + mdl_prod(e);
        if (s > HI) s = HI;
        if (s < LO) s = LO;
        mdl_acc = s;
    endfunction

    // Launches one strobe and reports edges-to-done, busy/hold behaviour and the resulting output.
    task automatic run_sample(input longint e, output int lat, output bit seq_ok,
                              output logic signed [N-1:0] outv);
        logic signed [N-1:0] prev;
        prev = out_ik_reg;
        @(negedge clk);
        en_reg = 1'b1;
        ek_act = N'(e);
        @(negedge clk);
        en_reg = 1'b0;
        lat    = 1;
        seq_ok = 1'b1;
        while (done !== 1'b1 && lat < 10) begin
            if (busy !== 1'b1 || out_ik_reg !== prev) seq_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) seq_ok = 1'b0;
        outv = out_ik_reg;
        @(negedge clk);
        if (done !== 1'b0) seq_ok = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mdl_acc = 0;
    endtask

    task automatic test_reset();
        int lat;
        bit ok;
        logic signed [N-1:0] o;
        rst = 1'b0;
        #12;
        n_checks++;
        if (out_ik_reg !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: out=%0d busy=%b done=%b, required 0/0/0", out_ik_reg, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        mdl_acc = 0;
        run_sample(25600, lat, ok, o);
        mdl_step(25600);
        n_checks++;
        if (o !== N'(mdl_acc)) begin
            n_fail++;
            $display("FAIL reset_preload: out=%0d, required %0d", o, mdl_acc);
        end
        @(negedge clk);
        en_reg = 1'b1;
        ek_act = 19'sd1024;
        @(negedge clk);
        en_reg = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_ik_reg !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: out=%0d busy=%b done=%b, required 0/0/0", out_ik_reg, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        mdl_acc = 0;
        run_sample(1024, lat, ok, o);
        mdl_step(1024);
        n_checks++;
        if (o !== N'(mdl_acc) || lat != 4 || !ok) begin
            n_fail++;
            $display("FAIL reset_after: out=%0d lat=%0d ok=%b, required %0d lat=4 ok=1", o, lat, ok, mdl_acc);
        end
    endtask

    task automatic test_step();
        int lat;
        bit ok;
        logic signed [N-1:0] o;
        do_clear();
        for (int i = 1; i <= 3; i++) begin
            int d0;
            d0 = done_cnt;
            run_sample(1024, lat, ok, o);
            mdl_step(1024);
            repeat (6) @(negedge clk);
            n_checks++;
            if (o !== N'(20 * i) || o !== N'(mdl_acc) || lat != 4 || !ok || done_cnt - d0 != 1) begin
                n_fail++;
                $display("FAIL step_%0d: out=%0d lat=%0d ok=%b dones=%0d, required %0d lat=4 ok=1 dones=1",
                         i, o, lat, ok, done_cnt - d0, 20 * i);
            end
        end
    endtask

    task automatic test_neg_floor();
        int lat;
        bit ok;
        logic signed [N-1:0] o;
        do_clear();
        run_sample(-1, lat, ok, o);
        mdl_step(-1);
        n_checks++;
        if (o !== -19'sd1 || o !== N'(mdl_acc)) begin
            n_fail++;
            $display("FAIL neg_floor: out=%0d, required -1", o);
        end
        run_sample(0, lat, ok, o);
        n_checks++;
        if (o !== -19'sd1 || lat != 4) begin
            n_fail++;
            $display("FAIL zero_error: out=%0d lat=%0d, required -1 lat=4", o, lat);
        end
    endtask

    task automatic test_windup();
        int lat;
        bit ok;
        int bad;
        logic signed [N-1:0] o;
        do_clear();
        bad = 0;
        for (int i = 0; i < 55; i++) begin
            run_sample(262143, lat, ok, o);
            mdl_step(262143);
            if (o !== N'(mdl_acc) || lat != 4 || !ok) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL windup_seq: %0d bad samples, required 0", bad);
        end
        n_checks++;
        if (o !== N'(HI)) begin
            n_fail++;
            $display("FAIL windup_limit: out=%0d, required %0d", o, HI);
        end
        run_sample(-262144, lat, ok, o);
        mdl_step(-262144);
        n_checks++;
        if (o !== N'(HI - 5120) || o !== N'(mdl_acc)) begin
            n_fail++;
            $display("FAIL unwind: out=%0d, required %0d", o, HI - 5120);
        end
        do_clear();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            run_sample(-262144, lat, ok, o);
            mdl_step(-262144);
            if (o !== N'(mdl_acc)) bad++;
        end
        n_checks++;
        if (bad != 0 || o !== N'(LO)) begin
            n_fail++;
            $display("FAIL windup_neg: out=%0d bad=%0d, required %0d bad=0", o, bad, LO);
        end
    endtask

    task automatic test_busy_strobe();
        int d0;
        do_clear();
        d0 = done_cnt;
        @(negedge clk);
        en_reg = 1'b1;
        ek_act = 19'sd1024;
        @(negedge clk);
        en_reg = 1'b0;
        @(negedge clk);
        en_reg = 1'b1;
        ek_act = 19'sd50000;
        @(negedge clk);
        en_reg = 1'b0;
        repeat (10) @(negedge clk);
        mdl_step(1024);
        n_checks++;
        if (done_cnt - d0 != 1 || out_ik_reg !== N'(mdl_acc)) begin
            n_fail++;
            $display("FAIL busy_strobe: dones=%0d out=%0d, required dones=1 out=%0d",
                     done_cnt - d0, out_ik_reg, mdl_acc);
        end
    endtask

    task automatic test_clr_priority();
        int lat;
        int d0;
        bit ok;
        logic signed [N-1:0] o;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            run_sample(1024, lat, ok, o);
            mdl_step(1024);
        end
        n_checks++;
        if (o !== 19'sd60) begin
            n_fail++;
            $display("FAIL clr_preload: out=%0d, required 60", o);
        end
        d0 = done_cnt;
        @(negedge clk);
        clr = 1'b1;
        en_reg = 1'b1;
        ek_act = 19'sd1024;
        @(negedge clk);
        clr = 1'b0;
        en_reg = 1'b0;
        mdl_acc = 0;
        n_checks++;
        if (out_ik_reg !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_en: out=%0d busy=%b done=%b, required 0/0/0", out_ik_reg, busy, done);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (done_cnt != d0 || out_ik_reg !== '0) begin
            n_fail++;
            $display("FAIL clr_drop: dones=%0d out=%0d, required 0 and 0", done_cnt - d0, out_ik_reg);
        end
        run_sample(1024, lat, ok, o);
        mdl_step(1024);
        n_checks++;
        if (o !== N'(mdl_acc)) begin
            n_fail++;
            $display("FAIL clr_resume: out=%0d, required %0d", o, mdl_acc);
        end
    endtask

    task automatic test_random();
        int lat;
        bit ok;
        longint e;
        logic signed [N-1:0] o;
        do_clear();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       e = longint'($urandom_range(0, 524287)) - 262144;
                1:       e = longint'($urandom_range(0, 4095)) - 2048;
                2:       e = ($urandom_range(0, 1) != 0) ? 262143 : -262144;
                default: e = longint'($urandom_range(0, 65535)) - 32768;
            endcase
            run_sample(e, lat, ok, o);
            mdl_step(e);
            n_checks++;
            if (o !== N'(mdl_acc) || lat != 4 || !ok) begin
                n_fail++;
                $display("FAIL random_%0d: ek=%0d out=%0d lat=%0d ok=%b, required %0d lat=4 ok=1",
                         i, e, o, lat, ok, mdl_acc);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        mdl_acc  = 0;
        en_reg   = 1'b0;
        clr      = 1'b0;
        ek_act   = '0;
        test_reset();
        test_step();
        test_neg_floor();
        test_windup();
        test_busy_strobe();
        test_clr_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
